// File: rtl/state_dumper.sv
// End-of-run state extractor: halts the core and streams a framed dump of the
// register file and data RAM (header, registers LSB-first, RAM, XOR checksum).
module state_dumper #(
    parameter int ADDR_BITS = 10,
    parameter int N         = 32,
    parameter int M         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 core_halt,
    output logic [4:0]           reg_addr,
    input  logic [N-1:0]         reg_rdata,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_en,
    input  logic [7:0]           ram_rdata,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready
);

    typedef enum logic [2:0] {IDLE, HDR, REG, FETCH, SEND, CSUM} state_t;

    localparam logic [7:0]         CNT_END   = 8'(4 * M);
    localparam logic [ADDR_BITS:0] ADDR_LAST = {1'b0, {ADDR_BITS{1'b1}}};

    state_t               state, state_n;
    logic [7:0]           cnt;
    logic [ADDR_BITS:0]   addr;
    logic [7:0]           data_q;
    logic [7:0]           csum;
    logic [7:0]           lane;
    logic                 xfer;

    // cnt indexes the next register byte to load, so the register file is
    // already addressed for the byte that follows the one on the wire.
    assign lane      = reg_rdata[{cnt[1:0], 3'b000} +: 8];
    assign xfer      = tx_valid && tx_ready;
    assign busy      = (state != IDLE);
    assign core_halt = busy;
    assign reg_addr  = cnt[6:2];
    assign ram_addr  = addr[ADDR_BITS-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        ram_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = HDR;
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = data_q;
                if (tx_ready) state_n = REG;
            end
            REG: begin
                tx_valid = 1'b1;
                tx_data  = data_q;
                if (tx_ready && cnt == CNT_END) state_n = FETCH;
            end
            FETCH: begin
                ram_en  = 1'b1;
                state_n = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = ram_rdata;
                if (tx_ready) state_n = (addr == ADDR_LAST) ? CSUM : FETCH;
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            addr <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == CSUM) && xfer;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= '0;
                        addr <= '0;
                    end
                end
                HDR, REG: begin
                    if (xfer && cnt != CNT_END) cnt <= cnt + 8'd1;
                end
                SEND: begin
                    if (xfer && addr != ADDR_LAST) addr <= addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Payload registers need no reset: they are reloaded on every start.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    data_q <= 8'hA5;
                    csum   <= 8'h00;
                end
            end
            HDR: begin
                if (xfer) data_q <= lane;
            end
            REG: begin
                if (xfer) begin
                    csum <= csum ^ data_q;
                    if (cnt != CNT_END) data_q <= lane;
                end
            end
            SEND: begin
                if (xfer) csum <= csum ^ ram_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_state_dumper.sv
// Directed bench for state_dumper: models the register file and RAM, predicts
// each frame into a scoreboard queue and compares every transferred byte.
module tb_state_dumper;

    localparam int FRAME_LEN = 1154;
    localparam int LIMIT     = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        core_halt;
    logic [4:0]  reg_addr;
    logic [31:0] reg_rdata;
    logic [9:0]  ram_addr;
    logic        ram_en;
    logic [7:0]  ram_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic [31:0] regs [0:31];
    logic [7:0]  ram  [0:1023];
    logic [7:0]  sb [$];
    logic [7:0]  rx_log [0:1199];
    int          rx_n;
    logic        stalled;
    logic [7:0]  held;
    int          n_cmp;
    int          n_bad;

    always #5 clk = ~clk;

    state_dumper dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .core_halt (core_halt),
        .reg_addr  (reg_addr),
        .reg_rdata (reg_rdata),
        .ram_addr  (ram_addr),
        .ram_en    (ram_en),
        .ram_rdata (ram_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    assign reg_rdata = regs[reg_addr];

    always @(posedge clk) begin
        if (ram_en) ram_rdata <= ram[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_pattern(input bit zero);
        for (int r = 0; r < 32; r++) regs[r] = zero ? 32'h0 : 32'h11223300 + 32'(r);
        for (int a = 0; a < 1024; a++) ram[a] = zero ? 8'h00 : 8'(a);
    endtask

    // Predict the whole frame from the memory models and request a dump.
    task automatic begin_frame();
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        sb.push_back(8'hA5);
        for (int r = 0; r < 32; r++) begin
            for (int l = 0; l < 4; l++) begin
                b = regs[r][8*l +: 8];
                sb.push_back(b);
                x = x ^ b;
            end
        end
        for (int a = 0; a < 1024; a++) begin
            sb.push_back(ram[a]);
            x = x ^ ram[a];
        end
        sb.push_back(x);
        rx_n  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // One clock: compare any byte transferred at the coming edge, and check
    // that a stalled byte was held with tx_valid kept high.
    task automatic cycle(input logic rdy);
        logic [7:0] e;
        tx_ready = rdy;
        if (stalled) begin
            check("valid_held_in_stall", {31'b0, tx_valid}, 32'd1);
            if (tx_valid) check("data_held_in_stall", {24'b0, tx_data}, {24'b0, held});
        end
        stalled = 1'b0;
        if (tx_valid) begin
            if (rdy) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check($sformatf("byte%0d", rx_n), {24'b0, tx_data}, {24'b0, e});
                end else begin
                    check("unexpected_byte_queue_size", sb.size(), 32'd1);
                end
                if (rx_n < 1200) rx_log[rx_n] = tx_data;
                rx_n++;
            end else begin
                stalled = 1'b1;
                held    = tx_data;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int pct, input int poke_at, output int k);
        k = 0;
        while (!done && k < LIMIT) begin
            start = (k == poke_at);
            cycle((pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < 32'(pct)));
            k++;
        end
        start = 1'b0;
        check("done_seen", {31'b0, done}, 32'd1);
        check("busy_low_at_done", {31'b0, busy}, 32'd0);
        check("scoreboard_drained", sb.size(), 32'd0);
        check("frame_length", rx_n, FRAME_LEN);
    endtask

    initial begin
        int k;
        int g;
        logic [7:0] x;
        n_cmp   = 0;
        n_bad   = 0;
        rx_n    = 0;
        stalled = 1'b0;
        held    = 8'h00;
        rst     = 1'b0;
        start   = 1'b0;
        tx_ready = 1'b1;
        load_pattern(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_done",      {31'b0, done},      32'd0);
        check("rst_core_halt", {31'b0, core_halt}, 32'd0);
        check("rst_tx_valid",  {31'b0, tx_valid},  32'd0);
        check("rst_tx_data",   {24'b0, tx_data},   32'h00);
        check("rst_ram_en",    {31'b0, ram_en},    32'd0);
        check("rst_ram_addr",  {22'b0, ram_addr},  32'd0);
        check("rst_reg_addr",  {27'b0, reg_addr},  32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Full-rate frame with the reference pattern.
        begin_frame();
        check("hdr_busy",      {31'b0, busy},      32'd1);
        check("hdr_core_halt", {31'b0, core_halt}, 32'd1);
        check("hdr_valid",     {31'b0, tx_valid},  32'd1);
        check("hdr_data",      {24'b0, tx_data},   32'hA5);
        wait_done(100, -1, k);
        check("done_latency", k, 32'd2178);
        check("rx0",    {24'b0, rx_log[0]},    32'hA5);
        check("rx1",    {24'b0, rx_log[1]},    32'h00);
        check("rx2",    {24'b0, rx_log[2]},    32'h33);
        check("rx3",    {24'b0, rx_log[3]},    32'h22);
        check("rx4",    {24'b0, rx_log[4]},    32'h11);
        check("rx125",  {24'b0, rx_log[125]},  32'h1F);
        check("rx126",  {24'b0, rx_log[126]},  32'h33);
        check("rx127",  {24'b0, rx_log[127]},  32'h22);
        check("rx128",  {24'b0, rx_log[128]},  32'h11);
        check("rx129",  {24'b0, rx_log[129]},  32'h00);
        check("rx1152", {24'b0, rx_log[1152]}, 32'hFF);
        x = 8'h00;
        for (int i = 1; i <= 1152; i++) x = x ^ rx_log[i];
        check("rx_checksum", {24'b0, rx_log[1153]}, {24'b0, x});
        cycle(1'b1);
        check("done_one_cycle", {31'b0, done}, 32'd0);

        // Random backpressure at roughly 30% ready.
        begin_frame();
        wait_done(30, -1, k);
        cycle(1'b1);

        // All-zero state.
        load_pattern(1'b1);
        begin_frame();
        wait_done(100, -1, k);
        check("zero_latency", k, 32'd2178);
        check("zero_checksum", {24'b0, rx_log[1153]}, 32'h00);
        load_pattern(1'b0);
        cycle(1'b1);

        // Reset while RAM byte 500 is in flight.
        begin_frame();
        g = 0;
        while (rx_n < 629 && g < LIMIT) begin
            cycle(1'b1);
            g++;
        end
        check("reached_ram_byte_500", rx_n, 32'd629);
        rst = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid",     {31'b0, tx_valid},  32'd0);
        check("mid_rst_busy",      {31'b0, busy},      32'd0);
        check("mid_rst_core_halt", {31'b0, core_halt}, 32'd0);
        check("mid_rst_done",      {31'b0, done},      32'd0);
        rst = 1'b1;
        sb.delete();
        stalled = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1);
            check("no_done_after_rst", {31'b0, done}, 32'd0);
        end
        begin_frame();
        check("post_rst_hdr", {24'b0, tx_data}, 32'hA5);
        wait_done(100, -1, k);
        check("post_rst_latency", k, 32'd2178);

        // start while busy is ignored; start in the done cycle is accepted.
        cycle(1'b1);
        begin_frame();
        wait_done(100, 50, k);
        check("busy_start_ignored_latency", k, 32'd2178);
        begin_frame();
        check("restart_valid", {31'b0, tx_valid}, 32'd1);
        check("restart_hdr",   {24'b0, tx_data},  32'hA5);
        check("restart_busy",  {31'b0, busy},     32'd1);
        wait_done(100, -1, k);
        check("restart_latency", k, 32'd2178);
        cycle(1'b1);

        // Header held under 100 cycles of backpressure.
        tx_ready = 1'b0;
        begin_frame();
        for (int i = 0; i < 100; i++) begin
            check("hold_valid",    {31'b0, tx_valid}, 32'd1);
            check("hold_hdr",      {24'b0, tx_data},  32'hA5);
            check("hold_reg_addr", {27'b0, reg_addr}, 32'd0);
            cycle(1'b0);
        end
        wait_done(100, -1, k);
        check("held_hdr_latency", k, 32'd2178);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
